// File: rtl/player_input_decoder.sv
// Frame-sampled keyboard decoder for two players: turns up to four HID usage codes
// into registered heading/move/fire per player plus a start pulse, updated once per vsync.
module player_input_decoder #(
  parameter int unsigned COOLDOWN_FRAMES = 20,
  parameter bit          AUTOFIRE        = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] keycodes,
  input  logic        frame_tick,
  input  logic        game_active,
  output logic [1:0]  dir_A,
  output logic        move_A,
  output logic        fire_A,
  output logic [1:0]  dir_B,
  output logic        move_B,
  output logic        fire_B,
  output logic        start_pulse,
  output logic        frame_strobe
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Key maps packed as {fire, right, left, down, up}; held masks use the same bit order.
  localparam logic [39:0] KEYMAP_A  = {8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A};
  localparam logic [39:0] KEYMAP_B  = {8'h28, 8'h4F, 8'h50, 8'h51, 8'h52};
  localparam logic [7:0]  KEY_START = 8'h13;
  localparam logic [7:0]  CD_LOAD   = 8'(COOLDOWN_FRAMES);

  function automatic logic [4:0] decode_held(input logic [31:0] kc, input logic [39:0] map);
    logic [4:0] h;
    h = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned b = 0; b < 5; b++) begin
        if (kc[8*i +: 8] == map[8*b +: 8]) h[b] = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic dir_e lowest_dir(input logic [3:0] m);
    if (m[0])      return DIR_UP;
    else if (m[1]) return DIR_DOWN;
    else if (m[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

  // Last-pressed-wins; a released heading falls back to any remaining held key.
  function automatic dir_e resolve_dir(input logic [3:0] held, input logic [3:0] prev,
                                       input dir_e cur);
    logic [3:0] new_press;
    new_press = held & ~prev;
    if (new_press != '0)  return lowest_dir(new_press);
    else if (held[cur])   return cur;
    else if (held != '0)  return lowest_dir(held);
    else                  return cur;
  endfunction

  // Vsync synchroniser and fall detector; idle level is high.
  logic vs_meta_q, vs_meta_d;
  logic vs_sync_q, vs_sync_d;
  logic vs_prev_q, vs_prev_d;
  logic frame_event;

  // Per-player state, index 0 = player A, 1 = player B.
  dir_e       dir_q  [2];
  dir_e       dir_d  [2];
  logic       move_q [2];
  logic       move_d [2];
  logic       fire_q [2];
  logic       fire_d [2];
  logic [4:0] prev_q [2];
  logic [4:0] prev_d [2];
  logic [7:0] cd_q   [2];
  logic [7:0] cd_d   [2];
  logic [7:0] cd_dec [2];
  logic [4:0] held   [2];

  logic start_held;
  logic start_prev_q, start_prev_d;
  logic start_pulse_q, start_pulse_d;
  logic frame_strobe_q, frame_strobe_d;

  assign frame_event = vs_prev_q & ~vs_sync_q;

  always_comb begin
    held[0]    = decode_held(keycodes, KEYMAP_A);
    held[1]    = decode_held(keycodes, KEYMAP_B);
    start_held = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (keycodes[8*i +: 8] == KEY_START) start_held = 1'b1;
    end
  end

  always_comb begin
    vs_meta_d      = frame_tick;
    vs_sync_d      = vs_meta_q;
    vs_prev_d      = vs_sync_q;
    frame_strobe_d = frame_event;
    start_prev_d   = start_prev_q;
    start_pulse_d  = start_pulse_q;
    for (int unsigned p = 0; p < 2; p++) begin
      dir_d[p]  = dir_q[p];
      move_d[p] = move_q[p];
      fire_d[p] = fire_q[p];
      prev_d[p] = prev_q[p];
      cd_d[p]   = cd_q[p];
      cd_dec[p] = (cd_q[p] != '0) ? cd_q[p] - 8'd1 : '0;
    end

    if (frame_event) begin
      start_prev_d  = start_held;
      start_pulse_d = start_held & ~start_prev_q;
      for (int unsigned p = 0; p < 2; p++) begin
        prev_d[p] = held[p];
        if (game_active) begin
          dir_d[p]  = resolve_dir(held[p][3:0], prev_q[p][3:0], dir_q[p]);
          move_d[p] = |held[p][3:0];
          fire_d[p] = (cd_dec[p] == '0) && held[p][4] && (!prev_q[p][4] || AUTOFIRE);
          cd_d[p]   = fire_d[p] ? CD_LOAD : cd_dec[p];
        end else begin
          move_d[p] = 1'b0;
          fire_d[p] = 1'b0;
          cd_d[p]   = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_meta_q      <= 1'b1;
      vs_sync_q      <= 1'b1;
      vs_prev_q      <= 1'b1;
      frame_strobe_q <= 1'b0;
      start_prev_q   <= 1'b0;
      start_pulse_q  <= 1'b0;
      for (int unsigned p = 0; p < 2; p++) begin
        dir_q[p]  <= DIR_UP;
        move_q[p] <= 1'b0;
        fire_q[p] <= 1'b0;
        prev_q[p] <= '0;
        cd_q[p]   <= '0;
      end
    end else begin
      vs_meta_q      <= vs_meta_d;
      vs_sync_q      <= vs_sync_d;
      vs_prev_q      <= vs_prev_d;
      frame_strobe_q <= frame_strobe_d;
      start_prev_q   <= start_prev_d;
      start_pulse_q  <= start_pulse_d;
      for (int unsigned p = 0; p < 2; p++) begin
        dir_q[p]  <= dir_d[p];
        move_q[p] <= move_d[p];
        fire_q[p] <= fire_d[p];
        prev_q[p] <= prev_d[p];
        cd_q[p]   <= cd_d[p];
      end
    end
  end

  assign dir_A        = dir_q[0];
  assign move_A       = move_q[0];
  assign fire_A       = fire_q[0];
  assign dir_B        = dir_q[1];
  assign move_B       = move_q[1];
  assign fire_B       = fire_q[1];
  assign start_pulse  = start_pulse_q;
  assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_player_input_decoder.sv
// Directed bench for player_input_decoder: two instances (edge fire / autofire, cooldown 3)
// share stimulus; each task checks its own expected values.
module tb_player_input_decoder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] keycodes;
  logic        frame_tick;
  logic        game_active;

  logic [1:0] dir_A, dir_B, f_dir_A, f_dir_B;
  logic       move_A, fire_A, move_B, fire_B, start_pulse, frame_strobe;
  logic       f_move_A, f_fire_A, f_move_B, f_fire_B, f_start_pulse, f_frame_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 Clk = ~Clk;

  player_input_decoder #(.COOLDOWN_FRAMES(3), .AUTOFIRE(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycodes(keycodes), .frame_tick(frame_tick),
    .game_active(game_active), .dir_A(dir_A), .move_A(move_A), .fire_A(fire_A),
    .dir_B(dir_B), .move_B(move_B), .fire_B(fire_B), .start_pulse(start_pulse),
    .frame_strobe(frame_strobe)
  );

  player_input_decoder #(.COOLDOWN_FRAMES(3), .AUTOFIRE(1'b1)) dut_af (
    .Clk(Clk), .Reset_n(Reset_n), .keycodes(keycodes), .frame_tick(frame_tick),
    .game_active(game_active), .dir_A(f_dir_A), .move_A(f_move_A), .fire_A(f_fire_A),
    .dir_B(f_dir_B), .move_B(f_move_B), .fire_B(f_fire_B), .start_pulse(f_start_pulse),
    .frame_strobe(f_frame_strobe)
  );

  task automatic do_frame(input logic [31:0] kc, input logic act);
    @(negedge Clk);
    keycodes    = kc;
    game_active = act;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge Clk);
    frame_tick = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    obs = {dir_A, move_A, fire_A, dir_B, move_B, fire_B, start_pulse, frame_strobe};
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 10'b0);
    end
    Reset_n     = 1'b1;
    keycodes    = 32'h0000001A;
    game_active = 1'b1;
    repeat (2) @(negedge Clk);
    frame_tick = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if ({frame_strobe, move_A} !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_early: strobe,move_A got %b expected 00", {frame_strobe, move_A});
    end
    @(posedge Clk);
    #1;
    obs = {frame_strobe, dir_A, move_A, dir_B, move_B, 3'b000};
    n_checks++;
    if (obs !== {1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL first_frame: got %b expected %b", obs, {1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 3'b000});
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if ({frame_strobe, move_A} !== 2'b01) begin
      n_fail++;
      $display("FAIL strobe_one_clk: strobe,move_A got %b expected 01", {frame_strobe, move_A});
    end
    @(negedge Clk);
    frame_tick = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_direction;
    logic [31:0] kc  [10];
    logic [7:0]  exp [10];
    logic [7:0]  obs;
    // {dir_A, move_A, dir_B, move_B, fire_A, fire_B}
    kc[0] = 32'h0000001A; exp[0] = {2'd0, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[1] = 32'h0000071A; exp[1] = {2'd3, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[2] = 32'h00000007; exp[2] = {2'd3, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[3] = 32'h00000000; exp[3] = {2'd3, 1'b0, 2'd0, 1'b0, 2'b00};
    kc[4] = 32'h00000416; exp[4] = {2'd1, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[5] = 32'h001A0416; exp[5] = {2'd0, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[6] = 32'h00000004; exp[6] = {2'd2, 1'b1, 2'd0, 1'b0, 2'b00};
    kc[7] = 32'h51334F51; exp[7] = {2'd2, 1'b0, 2'd1, 1'b1, 2'b00};
    kc[8] = 32'h0000004F; exp[8] = {2'd2, 1'b0, 2'd3, 1'b1, 2'b00};
    kc[9] = 32'h1A1A4F52; exp[9] = {2'd0, 1'b1, 2'd0, 1'b1, 2'b00};
    for (int i = 0; i < 10; i++) begin
      do_frame(kc[i], 1'b1);
      obs = {dir_A, move_A, dir_B, move_B, fire_A, fire_B};
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL direction[%0d] keys=%h: got %b expected %b", i, kc[i], obs, exp[i]);
      end
    end
  endtask

  task automatic test_fire_cooldown;
    logic [31:0] kc  [6];
    logic        exp [6];
    kc[0] = 32'h2C; exp[0] = 1'b1;
    kc[1] = 32'h00; exp[1] = 1'b0;
    kc[2] = 32'h2C; exp[2] = 1'b0;
    kc[3] = 32'h00; exp[3] = 1'b0;
    kc[4] = 32'h2C; exp[4] = 1'b1;
    kc[5] = 32'h2C; exp[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_frame(kc[i], 1'b1);
      n_checks++;
      if ({fire_A, f_fire_A} !== {exp[i], exp[i]}) begin
        n_fail++;
        $display("FAIL fire_cooldown[%0d]: fire_A,af_fire_A got %b expected %b",
                 i, {fire_A, f_fire_A}, {exp[i], exp[i]});
      end
    end
  endtask

  task automatic test_autofire;
    logic exp_af;
    logic exp_edge;
    do_frame(32'h0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      do_frame(32'h2C, 1'b1);
      exp_af   = (i == 1) || (i == 4) || (i == 7) || (i == 10);
      exp_edge = (i == 1);
      n_checks++;
      if ({f_fire_A, fire_A} !== {exp_af, exp_edge}) begin
        n_fail++;
        $display("FAIL autofire frame %0d: af,edge got %b expected %b",
                 i, {f_fire_A, fire_A}, {exp_af, exp_edge});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] obs;
    // {fire_A, fire_B, start_pulse, dir_B, move_B, move_A, frame_strobe}
    do_frame(32'h0, 1'b0);
    do_frame(32'h5213282C, 1'b1);
    obs = {fire_A, fire_B, start_pulse, dir_B, move_B, move_A, frame_strobe};
    n_checks++;
    if (obs !== {3'b111, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_active: got %b expected %b", obs, {3'b111, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    n_checks++;
    if ({f_fire_A, f_fire_B, f_start_pulse} !== 3'b111) begin
      n_fail++;
      $display("FAIL simul_active_af: got %b expected 111", {f_fire_A, f_fire_B, f_start_pulse});
    end
    do_frame(32'h4F, 1'b1);
    n_checks++;
    if ({dir_B, fire_A, fire_B, start_pulse} !== {2'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL simul_release: got %b expected %b", {dir_B, fire_A, fire_B, start_pulse}, {2'd3, 3'b000});
    end
    do_frame(32'h0, 1'b1);
    do_frame(32'h5213282C, 1'b0);
    obs = {fire_A, fire_B, start_pulse, dir_B, move_B, move_A, frame_strobe};
    n_checks++;
    if (obs !== {3'b001, 2'd3, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_inactive: got %b expected %b", obs, {3'b001, 2'd3, 1'b0, 1'b0, 1'b0});
    end
    n_checks++;
    if ({f_fire_A, f_fire_B, f_move_B} !== 3'b000) begin
      n_fail++;
      $display("FAIL simul_inactive_af: got %b expected 000", {f_fire_A, f_fire_B, f_move_B});
    end
    do_frame(32'h5213282C, 1'b1);
    obs = {fire_A, fire_B, start_pulse, dir_B, move_B, move_A, frame_strobe};
    n_checks++;
    if (obs !== {3'b000, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL round_start_held: got %b expected %b", obs, {3'b000, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    n_checks++;
    if ({f_fire_A, f_fire_B} !== 2'b11) begin
      n_fail++;
      $display("FAIL round_start_af: got %b expected 11", {f_fire_A, f_fire_B});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] obs;
    do_frame(32'h00002C07, 1'b1);
    n_checks++;
    if ({dir_A, move_A, fire_A} !== {2'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected %b", {dir_A, move_A, fire_A}, {2'd3, 1'b1, 1'b0});
    end
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    obs = {dir_A, move_A, fire_A, dir_B, move_B, fire_B, start_pulse, frame_strobe};
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %b expected %b", obs, 10'b0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    do_frame(32'h00002C07, 1'b1);
    n_checks++;
    if ({dir_A, move_A, fire_A, f_fire_A} !== {2'd3, 3'b111}) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %b expected %b", {dir_A, move_A, fire_A, f_fire_A}, {2'd3, 3'b111});
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    keycodes    = '0;
    frame_tick  = 1'b1;
    game_active = 1'b0;
    test_reset();
    test_direction();
    test_fire_cooldown();
    test_autofire();
    test_simultaneous();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
